decode_control_stage: RTL
=========================

DECODE_CONTROL_STAGE -- requirements
Module: decode_control_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter ENABLE_M, default 1; 0 makes M-extension encodings illegal.
REQ-003 SHALL have parameter MULDIV_CYCLES, default 4 (range 1-32), divider occupancy in cycles.
REQ-004 SHALL have port CLK  input  1  single clock, rising edge.
REQ-005 SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports IN_VALID input 1, IN_READY output 1; upstream handshake.
REQ-007 SHALL have ports INSTRUCTION input 32 and PC input XLEN; upstream payload.
REQ-008 SHALL have port FLUSH  input  1  synchronous squash of the stage.
REQ-009 SHALL have ports OUT_VALID output 1, OUT_READY input 1; downstream handshake.
REQ-010 SHALL have ports OUT_PC output XLEN, OUT_IMM output XLEN, and OUT_RD, OUT_RS1, OUT_RS2 output 5 each.
REQ-011 SHALL have ports OUT_ALU_OPCODE output 5 and OUT_FUNCT3 output 3.
REQ-012 SHALL have port OUT_CTRL output 8, bits [7:0] = WRITE_ENABLE, MEM_READ, MEM_WRITE, BRANCH, JUMP, JUMP_AND_LINK, IMMEDIATE_SELECT, OFFSET_GENERATOR.
REQ-013 SHALL have ports OUT_ILLEGAL output 1 and MULDIV_BUSY output 1.

Function
REQ-014 Decode SHALL cover LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP and (ENABLE_M=1) the eight M ops keyed on funct7=0000001.
REQ-015 ALU codes SHALL be: ADD 0, SUB 1, OR 2, XOR 3, AND 4, SRL 5, SLL 6, SRA 7, MUL 8, MULH 9, MULHU 10, MULHSU 11, DIV 12, DIVU 13, REM 14, REMU 15, SLT 16, SLTU 17, PASS_B 18 (LUI); branches SHALL use SUB.
REQ-016 OUT_IMM SHALL be the sign-extended I/S/B/U/J immediate selected by opcode; 0 for R-type.
REQ-017 Any unmatched opcode/funct3/funct7 combination SHALL set OUT_ILLEGAL=1 with OUT_CTRL=0.
REQ-018 A transfer SHALL occur when IN_VALID and IN_READY are both 1; the decoded result SHALL appear with OUT_VALID=1 on the next cycle (latency 1).
REQ-019 IN_READY SHALL be 1 only in IDLE/ISSUE with (!OUT_VALID or OUT_READY), outside MD_WAIT and BUBBLE.
REQ-020 Outputs SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 FSM states SHALL be IDLE, ISSUE, BUBBLE and MD_WAIT.
REQ-022 The load-use hazard SHALL be: captured instruction reads rs1/rs2 equal to a nonzero rd of the last load issued downstream.
REQ-023 On a load-use hazard the FSM SHALL enter BUBBLE: OUT_VALID=0 for exactly one cycle, then present the instruction.
REQ-024 When DIV/DIVU/REM/REMU issues with MULDIV_CYCLES>1, the FSM SHALL enter MD_WAIT for MULDIV_CYCLES-1 cycles with MULDIV_BUSY=1 and IN_READY=0.
REQ-025 FLUSH SHALL clear OUT_VALID, abandon BUBBLE and return to IDLE; an active MD_WAIT count SHALL continue.
REQ-026 FLUSH SHALL take priority over a simultaneous upstream transfer, which is not captured.
REQ-027 An rd of x0 SHALL never create a hazard.

Reset
REQ-028 RESET_N low SHALL force state IDLE, OUT_VALID=0, IN_READY=0, all payload outputs and counters 0, and the last-load record invalid.
REQ-029 Reset asserted mid-MD_WAIT or mid-BUBBLE SHALL abort both; IN_READY SHALL be 1 on the first clock edge after release.

Structure
REQ-030 Package rv32im_pkg SHALL hold the opcode constants, ALU code constants, OUT_CTRL bit indices and immediate-type encodings (I 000, S 001, J 010, B 011, U 100).
REQ-031 Immediate generation SHALL be a combinational sub-module imm_gen.

Verification
REQ-032 ADD x3,x1,x2 (0x002081B3): ALU=0, CTRL WRITE_ENABLE only, OUT_VALID=1 one cycle after acceptance.
REQ-033 LW x5,0(x1) then ADD x6,x5,x7: exactly one OUT_VALID=0 bubble cycle before the ADD.
REQ-034 DIV x4,x1,x2 with MULDIV_CYCLES=4: IN_READY=0 and MULDIV_BUSY=1 for 3 cycles after issue.
REQ-035 Opcode 0x7F, and MUL with ENABLE_M=0: OUT_ILLEGAL=1 and OUT_CTRL=0.
REQ-036 OUT_READY=0 for 5 cycles, then FLUSH coincident with IN_VALID: outputs stable, OUT_VALID=0 next cycle, new instruction not captured.
REQ-037 RESET_N pulse mid-MD_WAIT: OUT_VALID=0, MULDIV_BUSY=0, IN_READY=1 on the first edge after release.

Source files
------------

// File: rtl/rv32im_pkg.sv
// Shared RV32IM decode definitions: opcodes, ALU codes, control bit positions,
// immediate-type encodings and the instruction decode helper.
package rv32im_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUBBLE  = 2'd2,
        ST_MD_WAIT = 2'd3
    } dcs_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_OR     = 5'd2;
    localparam logic [4:0] ALU_XOR    = 5'd3;
    localparam logic [4:0] ALU_AND    = 5'd4;
    localparam logic [4:0] ALU_SRL    = 5'd5;
    localparam logic [4:0] ALU_SLL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_MUL    = 5'd8;
    localparam logic [4:0] ALU_MULH   = 5'd9;
    localparam logic [4:0] ALU_MULHU  = 5'd10;
    localparam logic [4:0] ALU_MULHSU = 5'd11;
    localparam logic [4:0] ALU_DIV    = 5'd12;
    localparam logic [4:0] ALU_DIVU   = 5'd13;
    localparam logic [4:0] ALU_REM    = 5'd14;
    localparam logic [4:0] ALU_REMU   = 5'd15;
    localparam logic [4:0] ALU_SLT    = 5'd16;
    localparam logic [4:0] ALU_SLTU   = 5'd17;
    localparam logic [4:0] ALU_PASS_B = 5'd18;

    localparam int unsigned CTRL_WRITE_ENABLE     = 32'd7;
    localparam int unsigned CTRL_MEM_READ         = 32'd6;
    localparam int unsigned CTRL_MEM_WRITE        = 32'd5;
    localparam int unsigned CTRL_BRANCH           = 32'd4;
    localparam int unsigned CTRL_JUMP             = 32'd3;
    localparam int unsigned CTRL_JUMP_AND_LINK    = 32'd2;
    localparam int unsigned CTRL_IMMEDIATE_SELECT = 32'd1;
    localparam int unsigned CTRL_OFFSET_GENERATOR = 32'd0;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_J    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    typedef struct packed {
        logic [4:0] alu;
        logic [7:0] ctrl;
        logic [2:0] imm_type;
        logic       illegal;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       is_load;
        logic       is_div;
    } decode_t;

    // Any illegal encoding collapses to an all-zero control word at the end.
    function automatic decode_t decode_instr(input logic [31:0] instr, input logic enable_m);
        decode_t    d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = instr[14:12];
        f7 = instr[31:25];
        d = '0;
        d.alu = ALU_ADD;
        d.imm_type = IMM_NONE;
        case (instr[6:0])
            OPC_LUI: begin
                d.alu = ALU_PASS_B;
                d.imm_type = IMM_U;
                d.ctrl[CTRL_WRITE_ENABLE] = 1'b1;
                d.ctrl[CTRL_IMMEDIATE_SELECT] = 1'b1;
            end
            OPC_AUIPC: begin
                d.imm_type = IMM_U;
                d.ctrl[CTRL_WRITE_ENABLE] = 1'b1;
                d.ctrl[CTRL_IMMEDIATE_SELECT] = 1'b1;
                d.ctrl[CTRL_OFFSET_GENERATOR] = 1'b1;
            end
            OPC_JAL: begin
                d.imm_type = IMM_J;
                d.ctrl[CTRL_WRITE_ENABLE] = 1'b1;
                d.ctrl[CTRL_JUMP] = 1'b1;
                d.ctrl[CTRL_JUMP_AND_LINK] = 1'b1;
                d.ctrl[CTRL_OFFSET_GENERATOR] = 1'b1;
            end
            OPC_JALR: begin
                d.imm_type = IMM_I;
                d.uses_rs1 = 1'b1;
                d.ctrl[CTRL_WRITE_ENABLE] = 1'b1;
                d.ctrl[CTRL_JUMP] = 1'b1;
                d.ctrl[CTRL_JUMP_AND_LINK] = 1'b1;
                d.ctrl[CTRL_IMMEDIATE_SELECT] = 1'b1;
                d.illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                d.alu = ALU_SUB;
                d.imm_type = IMM_B;
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                d.ctrl[CTRL_BRANCH] = 1'b1;
                d.ctrl[CTRL_OFFSET_GENERATOR] = 1'b1;
                d.illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                d.imm_type = IMM_I;
                d.uses_rs1 = 1'b1;
                d.is_load = 1'b1;
                d.ctrl[CTRL_WRITE_ENABLE] = 1'b1;
                d.ctrl[CTRL_MEM_READ] = 1'b1;
                d.ctrl[CTRL_IMMEDIATE_SELECT] = 1'b1;
                d.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                d.imm_type = IMM_S;
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                d.ctrl[CTRL_MEM_WRITE] = 1'b1;
                d.ctrl[CTRL_IMMEDIATE_SELECT] = 1'b1;
                d.illegal = f3[2] || (f3 == 3'b011);
            end
            OPC_OP_IMM: begin
                d.imm_type = IMM_I;
                d.uses_rs1 = 1'b1;
                d.ctrl[CTRL_WRITE_ENABLE] = 1'b1;
                d.ctrl[CTRL_IMMEDIATE_SELECT] = 1'b1;
                case (f3)
                    3'b000: d.alu = ALU_ADD;
                    3'b010: d.alu = ALU_SLT;
                    3'b011: d.alu = ALU_SLTU;
                    3'b100: d.alu = ALU_XOR;
                    3'b110: d.alu = ALU_OR;
                    3'b111: d.alu = ALU_AND;
                    3'b001: begin
                        d.alu = ALU_SLL;
                        d.illegal = (f7 != F7_BASE);
                    end
                    3'b101: begin
                        d.alu = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        d.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            OPC_OP: begin
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                d.ctrl[CTRL_WRITE_ENABLE] = 1'b1;
                case (f7)
                    F7_BASE: begin
                        case (f3)
                            3'b000:  d.alu = ALU_ADD;
                            3'b001:  d.alu = ALU_SLL;
                            3'b010:  d.alu = ALU_SLT;
                            3'b011:  d.alu = ALU_SLTU;
                            3'b100:  d.alu = ALU_XOR;
                            3'b101:  d.alu = ALU_SRL;
                            3'b110:  d.alu = ALU_OR;
                            3'b111:  d.alu = ALU_AND;
                            default: d.illegal = 1'b1;
                        endcase
                    end
                    F7_ALT: begin
                        case (f3)
                            3'b000:  d.alu = ALU_SUB;
                            3'b101:  d.alu = ALU_SRA;
                            default: d.illegal = 1'b1;
                        endcase
                    end
                    F7_MULDIV: begin
                        d.illegal = !enable_m;
                        d.is_div = f3[2];
                        case (f3)
                            3'b000:  d.alu = ALU_MUL;
                            3'b001:  d.alu = ALU_MULH;
                            3'b010:  d.alu = ALU_MULHSU;
                            3'b011:  d.alu = ALU_MULHU;
                            3'b100:  d.alu = ALU_DIV;
                            3'b101:  d.alu = ALU_DIVU;
                            3'b110:  d.alu = ALU_REM;
                            3'b111:  d.alu = ALU_REMU;
                            default: d.illegal = 1'b1;
                        endcase
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d = '0;
            d.illegal = 1'b1;
            d.alu = ALU_ADD;
            d.imm_type = IMM_NONE;
        end else begin
            d.illegal = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: extracts the I/S/B/U/J immediate from an
// instruction word and sign-extends it to XLEN; R-type yields zero.
module imm_gen
    import rv32im_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32_s;

    // Reassemble the scattered immediate bits for each format.
    always_comb begin
        case (imm_type)
            IMM_I:   imm32_s = {{20{instruction[31]}}, instruction[31:20]};
            IMM_S:   imm32_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            IMM_B:   imm32_s = {{19{instruction[31]}}, instruction[31], instruction[7],
                                instruction[30:25], instruction[11:8], 1'b0};
            IMM_U:   imm32_s = {instruction[31:12], 12'h000};
            IMM_J:   imm32_s = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                instruction[20], instruction[30:21], 1'b0};
            default: imm32_s = 32'h0000_0000;
        endcase
        imm = XLEN'($signed(imm32_s));
    end

endmodule

// File: rtl/decode_control_stage.sv
// Decode/control pipeline stage: one-cycle decode with valid/ready handshakes,
// a load-use bubble and divider occupancy stall.
module decode_control_stage
    import rv32im_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ENABLE_M      = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_alu_opcode,
    output logic [2:0]      out_funct3,
    output logic [7:0]      out_ctrl,
    output logic            out_illegal,
    output logic            muldiv_busy
);

    localparam logic       M_ON         = (ENABLE_M != 0);
    localparam logic       MD_MULTI     = (MULDIV_CYCLES > 1);
    localparam logic [4:0] MD_WAIT_INIT = 5'(MULDIV_CYCLES - 1);

    dcs_state_e      state_r, state_next_s;
    decode_t         dec_s;
    logic [XLEN-1:0] imm_s;
    logic            alive_r, out_valid_r, out_valid_next_s;
    logic            stage_open_s, take_s, hazard_s;
    logic            last_load_valid_r;
    logic [4:0]      last_load_rd_r;
    logic [4:0]      md_cnt_r;
    logic [XLEN-1:0] out_pc_r, out_imm_r;
    logic [4:0]      out_rd_r, out_rs1_r, out_rs2_r, out_alu_r;
    logic [2:0]      out_funct3_r;
    logic [7:0]      out_ctrl_r;
    logic            out_illegal_r, out_is_div_r;

    // Decode the upstream word.
    always_comb begin
        dec_s = decode_instr(instruction, M_ON);
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instruction (instruction),
        .imm_type    (dec_s.imm_type),
        .imm         (imm_s)
    );

    // Acceptance and load-use hazard detection; alive_r keeps ready low until the first edge after reset.
    always_comb begin
        stage_open_s = alive_r && ((state_r == ST_IDLE) || (state_r == ST_ISSUE))
                       && (!out_valid_r || out_ready);
        take_s = in_valid && stage_open_s && !flush;
        hazard_s = last_load_valid_r
                   && ((dec_s.uses_rs1 && (instruction[19:15] == last_load_rd_r))
                    || (dec_s.uses_rs2 && (instruction[24:20] == last_load_rd_r)));
    end

    // Next value of the downstream valid flag.
    always_comb begin
        if (flush) begin
            out_valid_next_s = 1'b0;
        end else if (state_r == ST_BUBBLE) begin
            out_valid_next_s = 1'b1;
        end else if (take_s) begin
            out_valid_next_s = !hazard_s;
        end else if (out_ready) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; a running divider count ignores flush.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_ISSUE: begin
                if (take_s && hazard_s) begin
                    state_next_s = ST_BUBBLE;
                end else if (take_s && dec_s.is_div && MD_MULTI) begin
                    state_next_s = ST_MD_WAIT;
                end else if (out_valid_next_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUBBLE: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (out_is_div_r && MD_MULTI) begin
                    state_next_s = ST_MD_WAIT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_MD_WAIT: begin
                if (md_cnt_r <= 5'd1) begin
                    state_next_s = out_valid_next_s ? ST_ISSUE : ST_IDLE;
                end else begin
                    state_next_s = ST_MD_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready    = stage_open_s;
        muldiv_busy = (state_r == ST_MD_WAIT);
    end

    // Ready enable, valid flag and divider occupancy counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alive_r     <= 1'b0;
            out_valid_r <= 1'b0;
            md_cnt_r    <= 5'd0;
        end else begin
            alive_r     <= 1'b1;
            out_valid_r <= out_valid_next_s;
            if ((state_next_s == ST_MD_WAIT) && (state_r != ST_MD_WAIT)) begin
                md_cnt_r <= MD_WAIT_INIT;
            end else if ((state_r == ST_MD_WAIT) && (md_cnt_r != 5'd0)) begin
                md_cnt_r <= md_cnt_r - 5'd1;
            end else begin
                md_cnt_r <= md_cnt_r;
            end
        end
    end

    // Payload capture; only a destination-writing load with nonzero rd arms the hazard record.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_pc_r          <= '0;
            out_imm_r         <= '0;
            out_rd_r          <= 5'd0;
            out_rs1_r         <= 5'd0;
            out_rs2_r         <= 5'd0;
            out_alu_r         <= 5'd0;
            out_funct3_r      <= 3'd0;
            out_ctrl_r        <= 8'd0;
            out_illegal_r     <= 1'b0;
            out_is_div_r      <= 1'b0;
            last_load_valid_r <= 1'b0;
            last_load_rd_r    <= 5'd0;
        end else if (take_s) begin
            out_pc_r          <= pc;
            out_imm_r         <= imm_s;
            out_rd_r          <= instruction[11:7];
            out_rs1_r         <= instruction[19:15];
            out_rs2_r         <= instruction[24:20];
            out_alu_r         <= dec_s.alu;
            out_funct3_r      <= instruction[14:12];
            out_ctrl_r        <= dec_s.ctrl;
            out_illegal_r     <= dec_s.illegal;
            out_is_div_r      <= dec_s.is_div;
            last_load_valid_r <= dec_s.is_load && (instruction[11:7] != 5'd0);
            last_load_rd_r    <= instruction[11:7];
        end else begin
            out_pc_r          <= out_pc_r;
            out_imm_r         <= out_imm_r;
            out_rd_r          <= out_rd_r;
            out_rs1_r         <= out_rs1_r;
            out_rs2_r         <= out_rs2_r;
            out_alu_r         <= out_alu_r;
            out_funct3_r      <= out_funct3_r;
            out_ctrl_r        <= out_ctrl_r;
            out_illegal_r     <= out_illegal_r;
            out_is_div_r      <= out_is_div_r;
            last_load_valid_r <= last_load_valid_r;
            last_load_rd_r    <= last_load_rd_r;
        end
    end

    assign out_valid      = out_valid_r;
    assign out_pc         = out_pc_r;
    assign out_imm        = out_imm_r;
    assign out_rd         = out_rd_r;
    assign out_rs1        = out_rs1_r;
    assign out_rs2        = out_rs2_r;
    assign out_alu_opcode = out_alu_r;
    assign out_funct3     = out_funct3_r;
    assign out_ctrl       = out_ctrl_r;
    assign out_illegal    = out_illegal_r;

endmodule
